// File: rtl/plc_scrambler_par.sv
// Beat-wide LFSR scrambler/descrambler with valid/ready handshake.
// MODE 0 additive, MODE 1 multiplicative scramble, MODE 2 multiplicative descramble.
module plc_scrambler_par #(
  parameter int unsigned         DATA_W   = 8,
  parameter int unsigned         LFSR_LEN = 7,
  parameter logic [LFSR_LEN-1:0] POLY     = 7'b1001000,
  parameter logic [LFSR_LEN-1:0] SEED     = 7'h7F,
  parameter int unsigned         MODE     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_sof,
  input  logic                in_bypass,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_sof,
  output logic [LFSR_LEN-1:0] lfsr_state
);

  if (LFSR_LEN < 2 || LFSR_LEN > 32) begin : g_bad_len
    $error("plc_scrambler_par: LFSR_LEN must be in 2..32");
  end
  if (POLY[LFSR_LEN-1] != 1'b1) begin : g_bad_poly
    $error("plc_scrambler_par: POLY must tap the oldest stage");
  end
  if (MODE > 2) begin : g_bad_mode
    $error("plc_scrambler_par: MODE must be 0, 1 or 2");
  end
  if (MODE == 0 && SEED == '0) begin : g_bad_seed
    $error("plc_scrambler_par: SEED must be non-zero in additive mode");
  end

  logic [LFSR_LEN-1:0] state_q;
  logic [LFSR_LEN-1:0] s;
  logic [LFSR_LEN-1:0] next_state;
  logic [DATA_W-1:0]   scr;
  logic [DATA_W-1:0]   next_data;
  logic                fb;
  logic                ob;
  logic                xfer;

  assign in_ready   = !out_valid || out_ready;
  assign xfer       = in_valid && in_ready;
  assign lfsr_state = state_q;

  // Unrolled per-bit stepping: bit 0 is earliest on the line and sees the starting state.
  always_comb begin
    s   = in_sof ? SEED : state_q;
    scr = '0;
    fb  = 1'b0;
    ob  = 1'b0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      fb     = ^(s & POLY);
      ob     = in_data[k] ^ fb;
      scr[k] = ob;
      if (MODE == 1)      s = {s[LFSR_LEN-2:0], ob};
      else if (MODE == 2) s = {s[LFSR_LEN-2:0], in_data[k]};
      else                s = {s[LFSR_LEN-2:0], fb};
    end
    next_state = in_bypass ? (in_sof ? SEED : state_q) : s;
    next_data  = in_bypass ? in_data : scr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      state_q   <= SEED;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= next_data;
      out_sof   <= in_sof;
      state_q   <= next_state;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plc_scrambler_par.sv
// Scoreboard bench for plc_scrambler_par: additive, chained, multiplicative loopback,
// backpressure, bypass/sof and mid-frame reset.
module tb_plc_scrambler_par;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // main additive instance
  logic       a_in_valid, a_in_ready, a_in_sof, a_in_bypass;
  logic [7:0] a_in_data, a_out_data;
  logic       a_out_valid, a_out_ready, a_out_sof;
  logic [6:0] a_lfsr;

  // chained additive pair
  logic       c_in_valid, c_in_ready, c_in_sof;
  logic [7:0] c_in_data, c1_out_data, c2_out_data;
  logic       c1_out_valid, c1_out_ready, c1_out_sof;
  logic       c2_out_valid, c2_out_sof;
  logic [6:0] c1_lfsr, c2_lfsr;

  // multiplicative pair
  logic       m_in_valid, m_in_ready, m_in_sof;
  logic [7:0] m_in_data, m_out_data, d_out_data;
  logic       m_out_valid, m_out_sof, d_in_ready, d_in_sof, force_sof;
  logic       d_out_valid, d_out_sof;
  logic [6:0] m_lfsr, d_lfsr;

  assign d_in_sof = m_out_sof | force_sof;

  plc_scrambler_par #(.DATA_W(8), .LFSR_LEN(7), .POLY(7'b1001000), .SEED(7'h7F), .MODE(0)) u_add (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_sof(a_in_sof), .in_bypass(a_in_bypass), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_sof(a_out_sof), .lfsr_state(a_lfsr));

  plc_scrambler_par #(.MODE(0)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_sof(c_in_sof), .in_bypass(1'b0), .out_valid(c1_out_valid), .out_ready(c1_out_ready),
    .out_data(c1_out_data), .out_sof(c1_out_sof), .lfsr_state(c1_lfsr));

  plc_scrambler_par #(.MODE(0)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(c1_out_valid), .in_ready(c1_out_ready), .in_data(c1_out_data),
    .in_sof(c1_out_sof), .in_bypass(1'b0), .out_valid(c2_out_valid), .out_ready(1'b1),
    .out_data(c2_out_data), .out_sof(c2_out_sof), .lfsr_state(c2_lfsr));

  plc_scrambler_par #(.MODE(1)) u_mul (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .in_sof(m_in_sof), .in_bypass(1'b0), .out_valid(m_out_valid), .out_ready(d_in_ready),
    .out_data(m_out_data), .out_sof(m_out_sof), .lfsr_state(m_lfsr));

  plc_scrambler_par #(.MODE(2)) u_demul (
    .clk(clk), .rst(rst), .in_valid(m_out_valid), .in_ready(d_in_ready), .in_data(m_out_data),
    .in_sof(d_in_sof), .in_bypass(1'b0), .out_valid(d_out_valid), .out_ready(1'b1),
    .out_data(d_out_data), .out_sof(d_out_sof), .lfsr_state(d_lfsr));

  typedef struct {logic [7:0] data; logic sof; logic [6:0] st;} exp_t;
  typedef struct {logic [7:0] data; bit chk;} lb_t;
  exp_t       q_a[$];
  logic [7:0] q_c[$];
  lb_t        q_d[$];
  exp_t       ea;
  logic [7:0] ec;
  lb_t        ed;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Scoreboard monitors: one pop per handshake cycle
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (q_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_extra: got %0h expected none", a_out_data);
      end else begin
        ea = q_a.pop_front();
        check("a_data", a_out_data, ea.data);
        check("a_sof", a_out_sof, ea.sof);
        check("a_state", a_lfsr, ea.st);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && c2_out_valid) begin
      if (q_c.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL c_extra: got %0h expected none", c2_out_data);
      end else begin
        ec = q_c.pop_front();
        check("chain_data", c2_out_data, ec);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && d_out_valid) begin
      if (q_d.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL d_extra: got %0h expected none", d_out_data);
      end else begin
        ed = q_d.pop_front();
        if (ed.chk) check("loop_data", d_out_data, ed.data);
      end
    end
  end

  task automatic a_send(input logic [7:0] d, input logic sof, input logic byp,
                        input logic [7:0] exp_d, input logic [6:0] exp_s, input bit push);
    int n = 0;
    if (push) q_a.push_back('{data: exp_d, sof: sof, st: exp_s});
    a_in_data = d; a_in_sof = sof; a_in_bypass = byp; a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin n++; @(negedge clk); end
    if (!a_in_ready) timeout_fail("a_accept");
    else @(posedge clk);
    #1 a_in_valid = 1'b0; a_in_sof = 1'b0; a_in_bypass = 1'b0;
  endtask

  task automatic c_send(input logic [7:0] d, input logic sof);
    int n = 0;
    q_c.push_back(d);
    c_in_data = d; c_in_sof = sof; c_in_valid = 1'b1;
    @(negedge clk);
    while (!c_in_ready && n < 50) begin n++; @(negedge clk); end
    if (!c_in_ready) timeout_fail("c_accept");
    else @(posedge clk);
    #1 c_in_valid = 1'b0; c_in_sof = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_a.size() + q_c.size() + q_d.size()) != 0 && n < 200) begin n++; @(posedge clk); end
    if ((q_a.size() + q_c.size() + q_d.size()) != 0) begin
      timeout_fail("drain");
      q_a.delete(); q_c.delete(); q_d.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; force_sof = 1'b0;
    a_in_valid = 1'b0; a_in_sof = 1'b0; a_in_bypass = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_sof = 1'b0; c_in_data = '0;
    m_in_valid = 1'b0; m_in_sof = 1'b0; m_in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_data", a_out_data, 8'h00);
    check("rst_out_sof", a_out_sof, 1'b0);
    check("rst_lfsr", a_lfsr, 7'h7F);
    check("rst_in_ready", a_in_ready, 1'b1);
    @(posedge clk); #1;

    // additive keystream with explicit 1-cycle latency check
    a_send(8'h00, 1'b1, 1'b0, 8'h70, 7'h0E, 1'b1);
    @(negedge clk);
    check("latency_valid", a_out_valid, 1'b1);
    check("latency_state", a_lfsr, 7'h0E);
    @(posedge clk); #1;
    a_send(8'h00, 1'b0, 1'b0, 8'h4F, 7'h72, 1'b1);
    a_send(8'hFF, 1'b1, 1'b0, 8'h8F, 7'h0E, 1'b1);

    // bypass / sof mix
    a_send(8'h00, 1'b1, 1'b0, 8'h70, 7'h0E, 1'b1);
    a_send(8'hAA, 1'b0, 1'b1, 8'hAA, 7'h0E, 1'b1);
    a_send(8'h00, 1'b0, 1'b0, 8'h4F, 7'h72, 1'b1);
    a_send(8'h00, 1'b1, 1'b0, 8'h70, 7'h0E, 1'b1);
    a_send(8'h55, 1'b1, 1'b1, 8'h55, 7'h7F, 1'b1);
    a_send(8'h00, 1'b0, 1'b0, 8'h70, 7'h0E, 1'b1);
    drain();

    // backpressure: second beat waits while the first is held
    a_out_ready = 1'b0;
    a_send(8'h00, 1'b1, 1'b0, 8'h70, 7'h0E, 1'b1);
    q_a.push_back('{data: 8'h4F, sof: 1'b0, st: 7'h72});
    a_in_data = 8'h00; a_in_sof = 1'b0; a_in_bypass = 1'b0; a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", a_out_valid, 1'b1);
      check("bp_data", a_out_data, 8'h70);
      check("bp_in_ready", a_in_ready, 1'b0);
      check("bp_lfsr", a_lfsr, 7'h0E);
    end
    @(posedge clk); #1 a_out_ready = 1'b1;
    a_send(8'h00, 1'b0, 1'b0, 8'h4F, 7'h72, 1'b0);
    drain();

    // reset mid-frame drops the held beat
    a_out_ready = 1'b0;
    a_send(8'h00, 1'b1, 1'b0, 8'h70, 7'h0E, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", a_out_valid, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", a_out_valid, 1'b0);
    check("mid_rst_lfsr", a_lfsr, 7'h7F);
    check("mid_rst_in_ready", a_in_ready, 1'b1);
    @(posedge clk); #1 a_out_ready = 1'b1;
    a_send(8'h00, 1'b0, 1'b0, 8'h70, 7'h0E, 1'b1);
    drain();

    // two additive instances in series recover the input
    c_send(8'hFF, 1'b1);
    c_send(8'h00, 1'b0);
    c_send(8'h5A, 1'b0);
    c_send(8'hAA, 1'b1);
    c_send(8'h3C, 1'b0);
    drain();

    // multiplicative loopback; descrambler reseeded under beat 32 must resync by beat 34
    for (int j = 0; j < 64; j++) begin
      m_in_data  = 8'($urandom);
      m_in_sof   = (j == 0);
      m_in_valid = 1'b1;
      force_sof  = (j == 33);
      q_d.push_back('{data: m_in_data, chk: !(j == 32 || j == 33)});
      @(negedge clk);
      if (!m_in_ready) timeout_fail("m_accept");
      @(posedge clk); #1;
    end
    m_in_valid = 1'b0; m_in_sof = 1'b0; force_sof = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
